// File: rtl/bw_operand_stage.sv
// Register-read / operand-issue stage feeding the BlackWidow ALU: resolves operands through
// ex/wb bypass, tracks one outstanding load, and presents a registered operand bundle.
//
// state | meaning
// EMPTY | no load in flight beyond the output register
// PEND  | a load has left this stage and its writeback to ld_rt is still outstanding
module bw_operand_stage #(
    parameter int AWID = 32,
    parameter int VWID = 80
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,

    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [39:0]     in_ir_i,
    input  logic [AWID-1:0] in_ip_i,
    input  logic [VWID-1:0] in_imm_i,
    input  logic [5:0]      in_ra_i,
    input  logic [5:0]      in_rb_i,
    input  logic [5:0]      in_rc_i,
    input  logic [5:0]      in_rt_i,
    input  logic            in_wr_i,
    input  logic            in_ld_i,

    output logic [5:0]      rfa_o,
    output logic [5:0]      rfb_o,
    output logic [5:0]      rfc_o,
    input  logic [VWID-1:0] rfa_i,
    input  logic [VWID-1:0] rfb_i,
    input  logic [VWID-1:0] rfc_i,

    input  logic [VWID-1:0] ex_res_i,

    input  logic            wb_wr_i,
    input  logic [5:0]      wb_rt_i,
    input  logic [VWID-1:0] wb_res_i,

    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [39:0]     out_ir_o,
    output logic [AWID-1:0] out_ip_o,
    output logic [VWID-1:0] out_a_o,
    output logic [VWID-1:0] out_b_o,
    output logic [VWID-1:0] out_c_o,
    output logic [VWID-1:0] out_imm_o,
    output logic [5:0]      out_rt_o,
    output logic            out_wr_o,
    output logic            out_ld_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        PEND  = 1'b1
    } sb_state_t;

    sb_state_t       sb_state;
    logic [5:0]      ld_rt;
    logic            ld_pend;
    logic            wb_clr;
    logic            ex_fwd;
    logic            out_ld_busy;
    logic            haz_a;
    logic            haz_b;
    logic            haz_c;
    logic            haz_ld;
    logic            hazard;
    logic            accept;
    logic            fire;
    logic            ld_issue;
    logic [VWID-1:0] opnd_a;
    logic [VWID-1:0] opnd_b;
    logic [VWID-1:0] opnd_c;

    assign rfa_o = in_ra_i;
    assign rfb_o = in_rb_i;
    assign rfc_o = in_rc_i;

    assign ld_pend     = (sb_state == PEND);
    assign wb_clr      = wb_wr_i && (wb_rt_i == ld_rt);
    assign ex_fwd      = out_valid_o && out_wr_o && !out_ld_o;
    assign out_ld_busy = out_valid_o && out_ld_o;

    // r0 is hardwired zero and never bypassed; ex beats wb beats regfile.
    function automatic logic [VWID-1:0] resolve(
        input logic [5:0]      n,
        input logic [VWID-1:0] rf,
        input logic            ex_ok,
        input logic [5:0]      ex_rt,
        input logic [VWID-1:0] ex_res,
        input logic            wb_wr,
        input logic [5:0]      wb_rt,
        input logic [VWID-1:0] wb_res
    );
        logic [VWID-1:0] r;
        r = rf;
        if (n == 6'd0)
            r = '0;
        else if (ex_ok && ex_rt == n)
            r = ex_res;
        else if (wb_wr && wb_rt == n)
            r = wb_res;
        return r;
    endfunction

    // A same-cycle writeback of the pending load is picked up by the wb bypass, so it does not stall.
    function automatic logic src_hazard(
        input logic [5:0] n,
        input logic       ld_busy,
        input logic [5:0] busy_rt,
        input logic       pend,
        input logic [5:0] pend_rt,
        input logic       clr
    );
        return (n != 6'd0) &&
               ((ld_busy && busy_rt == n) || (pend && pend_rt == n && !clr));
    endfunction

    assign opnd_a = resolve(in_ra_i, rfa_i, ex_fwd, out_rt_o, ex_res_i, wb_wr_i, wb_rt_i, wb_res_i);
    assign opnd_b = resolve(in_rb_i, rfb_i, ex_fwd, out_rt_o, ex_res_i, wb_wr_i, wb_rt_i, wb_res_i);
    assign opnd_c = resolve(in_rc_i, rfc_i, ex_fwd, out_rt_o, ex_res_i, wb_wr_i, wb_rt_i, wb_res_i);

    assign haz_a  = src_hazard(in_ra_i, out_ld_busy, out_rt_o, ld_pend, ld_rt, wb_clr);
    assign haz_b  = src_hazard(in_rb_i, out_ld_busy, out_rt_o, ld_pend, ld_rt, wb_clr);
    assign haz_c  = src_hazard(in_rc_i, out_ld_busy, out_rt_o, ld_pend, ld_rt, wb_clr);
    // Only one load may be outstanding beyond this stage.
    assign haz_ld = in_ld_i && (ld_pend || out_ld_busy);
    assign hazard = haz_a || haz_b || haz_c || haz_ld;

    assign in_ready_o = rst_ni && !flush_i && !hazard && (!out_valid_o || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign fire       = out_valid_o && out_ready_i;
    assign ld_issue   = fire && out_ld_o && out_wr_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_ir_o    <= '0;
            out_ip_o    <= '0;
            out_a_o     <= '0;
            out_b_o     <= '0;
            out_c_o     <= '0;
            out_imm_o   <= '0;
            out_rt_o    <= '0;
            out_wr_o    <= 1'b0;
            out_ld_o    <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_ir_o    <= in_ir_i;
            out_ip_o    <= in_ip_i;
            out_a_o     <= opnd_a;
            out_b_o     <= opnd_b;
            out_c_o     <= opnd_c;
            out_imm_o   <= in_imm_i;
            out_rt_o    <= in_rt_i;
            out_wr_o    <= in_wr_i;
            out_ld_o    <= in_ld_i;
        end else if (flush_i || fire) begin
            out_valid_o <= 1'b0;
        end
    end

    // A flush leaves the scoreboard alone: a load already issued still writes back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_state <= EMPTY;
            ld_rt    <= '0;
        end else begin
            case (sb_state)
                EMPTY: begin
                    if (ld_issue) begin
                        sb_state <= PEND;
                        ld_rt    <= out_rt_o;
                    end
                end
                PEND: begin
                    if (ld_issue) begin
                        sb_state <= PEND;
                        ld_rt    <= out_rt_o;
                    end else if (wb_clr) begin
                        sb_state <= EMPTY;
                    end
                end
                default: sb_state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_operand_stage.sv
// Directed bench for bw_operand_stage: issued bundles go into an expectation queue that a
// negedge monitor drains on every output transfer.
module tb_bw_operand_stage;

    typedef struct packed {
        logic [39:0] ir;
        logic [31:0] ip;
        logic [79:0] a;
        logic [79:0] b;
        logic [79:0] c;
        logic [79:0] imm;
        logic [5:0]  rt;
        logic        wr;
        logic        ld;
    } bund_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_ir;
    logic [31:0] in_ip;
    logic [79:0] in_imm;
    logic [5:0]  in_ra, in_rb, in_rc, in_rt;
    logic        in_wr, in_ld;
    logic [5:0]  rfa, rfb, rfc;
    logic [79:0] rfa_d, rfb_d, rfc_d;
    logic [79:0] ex_res;
    logic        wb_wr;
    logic [5:0]  wb_rt;
    logic [79:0] wb_res;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_ir;
    logic [31:0] out_ip;
    logic [79:0] out_a, out_b, out_c, out_imm;
    logic [5:0]  out_rt;
    logic        out_wr, out_ld;

    logic [79:0] regs [64];
    bund_t       expq [$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] ip_ctr = 32'h100;

    assign rfa_d = regs[rfa];
    assign rfb_d = regs[rfb];
    assign rfc_d = regs[rfc];

    bw_operand_stage #(.AWID(32), .VWID(80)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ir_i(in_ir), .in_ip_i(in_ip), .in_imm_i(in_imm),
        .in_ra_i(in_ra), .in_rb_i(in_rb), .in_rc_i(in_rc), .in_rt_i(in_rt),
        .in_wr_i(in_wr), .in_ld_i(in_ld),
        .rfa_o(rfa), .rfb_o(rfb), .rfc_o(rfc),
        .rfa_i(rfa_d), .rfb_i(rfb_d), .rfc_i(rfc_d),
        .ex_res_i(ex_res),
        .wb_wr_i(wb_wr), .wb_rt_i(wb_rt), .wb_res_i(wb_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ir_o(out_ir), .out_ip_o(out_ip), .out_a_o(out_a), .out_b_o(out_b),
        .out_c_o(out_c), .out_imm_o(out_imm),
        .out_rt_o(out_rt), .out_wr_o(out_wr), .out_ld_o(out_ld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every transfer (valid && ready, not flushed) must match the oldest expectation.
    always @(negedge clk) begin
        bund_t got, e;
        if (rst_n && out_valid && out_ready && !flush) begin
            got = '{out_ir, out_ip, out_a, out_b, out_c, out_imm, out_rt, out_wr, out_ld};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_transfer ip=%h ir=%h", out_ip, out_ir);
            end else begin
                e = expq.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL bundle ip got=%h exp=%h a got=%h exp=%h b got=%h exp=%h c got=%h exp=%h rt/wr/ld got=%h/%b/%b exp=%h/%b/%b",
                             got.ip, e.ip, got.a, e.a, got.b, e.b, got.c, e.c,
                             got.rt, got.wr, got.ld, e.rt, e.wr, e.ld);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [39:0] ir, input logic [5:0] ra, input logic [5:0] rb,
                        input logic [5:0] rc, input logic [5:0] rt, input logic wr, input logic ld,
                        input logic [79:0] ea, input logic [79:0] eb, input logic [79:0] ec,
                        output int stalls);
        bund_t e;
        bit    done;
        e = '{ir, ip_ctr, ea, eb, ec, {48'h0, ip_ctr} ^ 80'h5A5A, rt, wr, ld};
        expq.push_back(e);
        in_ir = ir; in_ip = ip_ctr; in_imm = e.imm;
        in_ra = ra; in_rb = rb; in_rc = rc; in_rt = rt; in_wr = wr; in_ld = ld;
        in_valid = 1'b1;
        stalls = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 40) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout ip=%h stalls=%0d limit=40", ip_ctr, stalls);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ip_ctr += 32'd4;
    endtask

    task automatic wb_pulse(input int delay, input logic [5:0] rt, input logic [79:0] res);
        repeat (delay) @(posedge clk);
        #1;
        wb_wr = 1'b1; wb_rt = rt; wb_res = res;
        @(posedge clk);
        #1;
        wb_wr = 1'b0;
    endtask

    initial begin
        int    st;
        bund_t snap;
        for (int i = 0; i < 64; i++) regs[i] = 80'h1000 + 80'(i);
        regs[0] = 80'hEE; regs[1] = 80'd5; regs[2] = 80'd7; regs[3] = 80'd99;
        regs[5] = 80'h55; regs[6] = 80'h77; regs[10] = 80'h66;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_ir = '0; in_ip = '0; in_imm = '0;
        in_ra = '0; in_rb = '0; in_rc = '0; in_rt = '0; in_wr = 1'b0; in_ld = 1'b0;
        ex_res = '0; wb_wr = 1'b0; wb_rt = '0; wb_res = '0;

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 80'(out_valid), 80'd0);
        chk("reset_in_ready", 80'(in_ready), 80'd0);
        chk("reset_out_a", out_a, 80'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back dependent ALU ops through the ex bypass.
        send(40'h01_0000_0001, 6'd1, 6'd2, 6'd0, 6'd3, 1'b1, 1'b0, 80'd5, 80'd7, 80'd0, st);
        chk("dep_first_stalls", 80'(st), 80'd0);
        ex_res = 80'd12;
        send(40'h01_0000_0002, 6'd3, 6'd3, 6'd0, 6'd4, 1'b1, 1'b0, 80'd12, 80'd12, 80'd0, st);
        chk("dep_second_stalls", 80'(st), 80'd0);

        // Bypass priority: ex over wb, wb alone, r0 never bypassed.
        send(40'h02_0000_0001, 6'd1, 6'd0, 6'd0, 6'd5, 1'b1, 1'b0, 80'd5, 80'd0, 80'd0, st);
        ex_res = 80'h10; wb_wr = 1'b1; wb_rt = 6'd5; wb_res = 80'h20;
        send(40'h02_0000_0002, 6'd5, 6'd0, 6'd0, 6'd7, 1'b1, 1'b0, 80'h10, 80'd0, 80'd0, st);
        send(40'h02_0000_0003, 6'd5, 6'd0, 6'd0, 6'd0, 1'b1, 1'b0, 80'h20, 80'd0, 80'd0, st);
        ex_res = 80'h33; wb_rt = 6'd0; wb_res = 80'hFF;
        send(40'h02_0000_0004, 6'd0, 6'd0, 6'd0, 6'd15, 1'b0, 1'b0, 80'd0, 80'd0, 80'd0, st);
        wb_wr = 1'b0;

        // Load-use stall, released by the same-cycle writeback of r6.
        send(40'h03_0000_0001, 6'd1, 6'd0, 6'd0, 6'd6, 1'b1, 1'b1, 80'd5, 80'd0, 80'd0, st);
        fork
            send(40'h03_0000_0002, 6'd6, 6'd2, 6'd0, 6'd8, 1'b1, 1'b0, 80'hABCD, 80'd7, 80'd0, st);
            wb_pulse(3, 6'd6, 80'hABCD);
        join
        chk("load_use_stalls", 80'(st), 80'd3);
        send(40'h03_0000_0003, 6'd0, 6'd0, 6'd0, 6'd9, 1'b1, 1'b1, 80'd0, 80'd0, 80'd0, st);
        chk("load_after_clear_stalls", 80'(st), 80'd0);
        // Second load waits until the scoreboard entry is cleared (one edge after writeback).
        fork
            send(40'h03_0000_0004, 6'd0, 6'd0, 6'd0, 6'd10, 1'b1, 1'b1, 80'd0, 80'd0, 80'd0, st);
            wb_pulse(4, 6'd9, 80'h99);
        join
        chk("second_load_stalls", 80'(st), 80'd5);

        // Flush while held: output drops, input refused, pending load on r10 retained.
        send(40'h04_0000_0001, 6'd1, 6'd0, 6'd0, 6'd11, 1'b1, 1'b0, 80'd5, 80'd0, 80'd0, st);
        chk("pre_flush_stalls", 80'(st), 80'd0);
        out_ready = 1'b0;
        flush = 1'b1; in_valid = 1'b1; in_ra = 6'd2; in_ld = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 80'(in_ready), 80'd0);
        chk("flush_out_valid_before", 80'(out_valid), 80'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        void'(expq.pop_back());
        chk("flush_out_valid_after", 80'(out_valid), 80'd0);
        out_ready = 1'b1;
        fork
            send(40'h04_0000_0002, 6'd10, 6'd0, 6'd0, 6'd12, 1'b1, 1'b0, 80'hBEEF, 80'd0, 80'd0, st);
            wb_pulse(2, 6'd10, 80'hBEEF);
        join
        chk("flush_ld_pend_stalls", 80'(st), 80'd2);
        @(posedge clk); #1;

        // Backpressure: output held stable 4 cycles, then one transfer per cycle.
        out_ready = 1'b0;
        send(40'h05_0000_0001, 6'd1, 6'd0, 6'd0, 6'd13, 1'b1, 1'b0, 80'd5, 80'd0, 80'd0, st);
        snap = '{out_ir, out_ip, out_a, out_b, out_c, out_imm, out_rt, out_wr, out_ld};
        fork
            send(40'h05_0000_0002, 6'd2, 6'd0, 6'd0, 6'd16, 1'b1, 1'b0, 80'd7, 80'd0, 80'd0, st);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    total++;
                    if ({out_ir, out_ip, out_a, out_b, out_c, out_imm, out_rt, out_wr, out_ld} !== snap
                        || !out_valid || in_ready) begin
                        bad++;
                        $display("FAIL backpressure_hold cycle=%0d got ip=%h a=%h ready=%b exp ip=%h a=%h ready=0",
                                 k, out_ip, out_a, in_ready, snap.ip, snap.a);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("backpressure_stalls", 80'(st), 80'd4);
        send(40'h05_0000_0003, 6'd1, 6'd2, 6'd0, 6'd17, 1'b1, 1'b0, 80'd5, 80'd7, 80'd0, st);
        chk("backpressure_resume_stalls", 80'(st), 80'd0);
        @(posedge clk); #1;

        // Asynchronous reset while a bundle is held.
        out_ready = 1'b0;
        send(40'h06_0000_0001, 6'd1, 6'd2, 6'd0, 6'd3, 1'b1, 1'b0, 80'd5, 80'd7, 80'd0, st);
        void'(expq.pop_back());
        in_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 80'(out_valid), 80'd0);
        chk("midreset_out_a", out_a, 80'd0);
        chk("midreset_in_ready", 80'(in_ready), 80'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(40'h06_0000_0002, 6'd2, 6'd1, 6'd0, 6'd14, 1'b1, 1'b0, 80'd7, 80'd5, 80'd0, st);
        chk("post_reset_stalls", 80'(st), 80'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 80'(expq.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bw_operand_stage.md
# bw_operand_stage

Register-read / operand-issue stage sitting directly upstream of the BlackWidow ALU. Accepts decoded instructions, reads the register file, resolves operands by bypassing from the ALU and writeback, and presents a registered operand bundle (ir, ip, a, b, c, imm) to the ALU under valid/ready handshake. Detects load-use hazards with a single-entry pending-load scoreboard and stalls upstream until the load writes back.

## Interface
- AWID, 32, width of ip (Address)
- VWID, 80, operand/result width (Value)
- clk_i  in  1  clock; all state changes on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard output register contents (branch redirect)
- in_valid_i / in_ready_o  in/out  1  upstream handshake; transfer when both high
- in_ir_i  in  40  instruction (5 bytes)
- in_ip_i  in  AWID  instruction address
- in_imm_i  in  VWID  immediate, already extended by decode
- in_ra_i, in_rb_i, in_rc_i, in_rt_i  in  6 each  source/target register numbers
- in_wr_i  in  1  instruction writes in_rt_i
- in_ld_i  in  1  instruction is a load (result arrives at writeback)
- rfa_o, rfb_o, rfc_o  out  6 each  regfile read addresses (= in_ra_i/rb/rc, combinational)
- rfa_i, rfb_i, rfc_i  in  VWID each  regfile read data, same cycle
- ex_res_i  in  VWID  ALU result for instruction in output register (combinational)
- wb_wr_i, wb_rt_i, wb_res_i  in  1/6/VWID  writeback port
- out_valid_o / out_ready_i  out/in  1  downstream (ALU) handshake
- out_ir_o, out_ip_o, out_a_o, out_b_o, out_c_o, out_imm_o  out  40/AWID/VWID×4  registered bundle
- out_rt_o, out_wr_o, out_ld_o  out  6/1/1  registered target info

## Operation
- Operand resolve per source s∈{a,b,c}, register n: n==0 → 0 (never bypassed); else priority ex > wb > regfile.
  - ex hit: out_valid_o && out_wr_o && !out_ld_o && out_rt_o==n → ex_res_i.
  - wb hit: wb_wr_i && wb_rt_i==n → wb_res_i.
  - else rf*_i.
- Pending-load scoreboard: ld_pend (1 bit), ld_rt (6 bits). States EMPTY (ld_pend=0), PEND (ld_pend=1).
  - Set (→PEND, ld_rt=out_rt_o) when output fires with out_ld_o=1 and out_wr_o=1.
  - Clear (→EMPTY) when wb_wr_i && wb_rt_i==ld_rt. Clear and set same cycle → set wins.
- Hazard (blocks acceptance), for any used source n≠0:
  - out_valid_o && out_ld_o && out_rt_o==n;
  - ld_pend && ld_rt==n && !(wb_wr_i && wb_rt_i==ld_rt) (same-cycle writeback resolves via wb bypass).
  - in_ld_i && (ld_pend || (out_valid_o && out_ld_o)): max one load beyond this stage.
- in_ready_o = rst_ni && !flush_i && !hazard && (!out_valid_o || out_ready_i).
- Accept: output register loads bundle with resolved operands; out_valid_o←1.
- Output fires without accept: out_valid_o←0. Held otherwise (contents stable while out_valid_o && !out_ready_i).
- flush_i: out_valid_o←0 next edge regardless of out_ready_i; no accept that cycle; ld_pend/ld_rt unchanged (issued load still writes back).

## Timing
- Reset (async assert): out_valid_o=0, all out_* data=0, ld_pend=0, ld_rt=0; in_ready_o=0 while rst_ni low, 1 first cycle after release if in_valid_i with no hazard.
- Latency 1 cycle: accepted on edge k → out_valid_o high after edge k.
- Full throughput: back-to-back accept when out_ready_i=1, including dependent ALU ops (ex bypass).
- Load-use: dependent op stalls ≥1 cycle after load leaves; accepted in cycle wb writes ld_rt.
- Paths in_*/rf*_i/ex_res_i/wb_* → out_* registers are single-cycle combinational.

## Test plan
- Reset mid-stream: out_valid_o=1 holding ADD, assert rst_ni=0 → out_valid_o=0, out_a_o=0 immediately; release → accept next valid.
- Back-to-back dependency: ADD r3=r1+r2 (r1=5,r2=7), then ADD r4=r3+r3 with ex_res_i=12 → second out_a_o=out_b_o=12, no stall.
- Priority: ex hit r5=0x10 and wb_wr r5=0x20 same cycle → operand 0x10; only wb hit → 0x20; source r0 with wb_rt_i=0 → 0.
- Load-use: load r6 fires, next ADD uses r6 → in_ready_o=0 for 3 cycles until wb_wr_i r6=0xABCD, accepted that cycle with out_a_o=0xABCD; second load while ld_pend → stalled.
- Backpressure: out_ready_i=0 for 4 cycles → out_* stable, in_ready_o=0; release → one transfer per cycle, no loss/duplication.
- Flush: out_valid_o=1, out_ready_i=0, flush_i=1 with in_valid_i=1 → out_valid_o=0 next cycle, input not accepted; ld_pend retained.
